// File: rtl/radix2_seq_multiplier.sv
// radix2_seq_multiplier
// Sequential shift-and-add multiplier. It processes one multiplier bit per clock.
// An accepted operation spends WIDTH cycles in CALC and one cycle in DONE.
//
// Optional feature: defining the macro SIGNED_MULT_EN adds the signed_mode port.
// When signed_mode=1 is sampled on the accepting edge, the multiplier uses
// radix-2 Booth recoding for two's-complement operands.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   start        operation request, accepted only in IDLE when abort=0
//   abort        cancels an operation in CALC; ignored in DONE
//   a            multiplicand, sampled on the accepting edge
//   b            multiplier, sampled on the accepting edge
//   signed_mode  two's-complement select (SIGNED_MULT_EN builds only)
//   busy         high in CALC and DONE
//   done         one-cycle pulse, product valid
//   product      {accumulator, multiplier register}; held until the next accept

module radix2_seq_multiplier #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
`ifdef SIGNED_MULT_EN
  input  logic               signed_mode,
`endif
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] mplier_q;
  logic             busy_q;
  logic             done_q;
`ifdef SIGNED_MULT_EN
  logic             signed_q;
  logic             qm1_q;
`endif

  // The sum is one bit wider than the accumulator.
  // In unsigned mode the top bit is the carry, and the right shift moves it into the accumulator MSB.
  // In Booth mode the top bit is the true sign, so the same shift is arithmetic.
  logic [WIDTH:0] sum;

  always_comb begin
    sum = {1'b0, acc_q};
`ifdef SIGNED_MULT_EN
    if (signed_q) begin
      unique case ({mplier_q[0], qm1_q})
        2'b01:   sum = {acc_q[WIDTH-1], acc_q} + {mcand_q[WIDTH-1], mcand_q};
        2'b10:   sum = {acc_q[WIDTH-1], acc_q} - {mcand_q[WIDTH-1], mcand_q};
        default: sum = {acc_q[WIDTH-1], acc_q};
      endcase
    end else if (mplier_q[0]) begin
      sum = {1'b0, acc_q} + {1'b0, mcand_q};
    end
`else
    if (mplier_q[0]) begin
      sum = {1'b0, acc_q} + {1'b0, mcand_q};
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SIGNED_MULT_EN
      signed_q <= 1'b0;
      qm1_q    <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (start && !abort) begin
            mcand_q  <= a;
            mplier_q <= b;
            acc_q    <= '0;
            cnt_q    <= CntW'(WIDTH);
            busy_q   <= 1'b1;
            state_q  <= StCalc;
`ifdef SIGNED_MULT_EN
            signed_q <= signed_mode;
            qm1_q    <= 1'b0;
`endif
          end
        end
        StCalc: begin
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            acc_q    <= sum[WIDTH:1];
            mplier_q <= {sum[0], mplier_q[WIDTH-1:1]};
            cnt_q    <= cnt_q - CntW'(1);
`ifdef SIGNED_MULT_EN
            qm1_q    <= mplier_q[0];
`endif
            if (cnt_q == CntW'(1)) begin
              done_q  <= 1'b1;
              state_q <= StDone;
            end
          end
        end
        StDone: begin
          // abort is deliberately not examined here
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = {acc_q, mplier_q};

endmodule
